// File: rtl/cwwppb_soc.sv
// cwwppb_soc: single-cycle RV32I core executing from a 4096-word on-chip ROM.
// Build option UART_DEBUG_EN: uart_debug_pin high stalls the core (pc and registers hold).

module cwwppb_rom (
  input  logic [11:0] addr_i,
  output logic [31:0] data_o
);
  reg [31:0] _rom [0:4095];

  assign data_o = _rom[addr_i];
endmodule

module cwwppb_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o
);
  reg [31:0] regs [0:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == 5'd0) ? '0 : regs[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? '0 : regs[raddr_b_i];
endmodule

module cwwppb_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic [31:0] instr_i,
  output logic [11:0] rom_addr_o
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd_addr, rs1_addr, rs2_addr;
  logic [31:0] imm_i, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, jalr_sum;
  logic        wb_en, take;
  logic [31:0] wb_data;

  assign opcode   = instr_i[6:0];
  assign rd_addr  = instr_i[11:7];
  assign funct3   = instr_i[14:12];
  assign rs1_addr = instr_i[19:15];
  assign rs2_addr = instr_i[24:20];
  assign funct7   = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'd0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  assign pc_plus4   = pc_q + 32'd4;
  assign jalr_sum   = rs1_val + imm_i;
  assign rom_addr_o = pc_q[13:2];

  cwwppb_regs u_regs (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wb_en & ~stall_i),
    .waddr_i   (rd_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (rs1_addr),
    .raddr_b_i (rs2_addr),
    .rdata_a_o (rs1_val),
    .rdata_b_o (rs2_val)
  );

  // Anything not decoded below (loads, stores, system, malformed encodings) falls through as a NOP.
  always_comb begin
    wb_en   = 1'b0;
    wb_data = '0;
    take    = 1'b0;
    pc_d    = pc_plus4;
    case (opcode)
      OP_LUI: begin
        wb_en   = 1'b1;
        wb_data = imm_u;
      end
      OP_AUIPC: begin
        wb_en   = 1'b1;
        wb_data = pc_q + imm_u;
      end
      OP_JAL: begin
        wb_en   = 1'b1;
        wb_data = pc_plus4;
        pc_d    = pc_q + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          wb_en   = 1'b1;
          wb_data = pc_plus4;
          pc_d    = {jalr_sum[31:1], 1'b0};
        end
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000:  take = (rs1_val == rs2_val);
          3'b001:  take = (rs1_val != rs2_val);
          3'b100:  take = ($signed(rs1_val) < $signed(rs2_val));
          3'b101:  take = ($signed(rs1_val) >= $signed(rs2_val));
          3'b110:  take = (rs1_val < rs2_val);
          3'b111:  take = (rs1_val >= rs2_val);
          default: take = 1'b0;
        endcase
        if (take) pc_d = pc_q + imm_b;
      end
      OP_IMM: begin
        wb_en = 1'b1;
        case (funct3)
          3'b000: wb_data = rs1_val + imm_i;
          3'b010: wb_data = {31'd0, $signed(rs1_val) < $signed(imm_i)};
          3'b011: wb_data = {31'd0, rs1_val < imm_i};
          3'b100: wb_data = rs1_val ^ imm_i;
          3'b110: wb_data = rs1_val | imm_i;
          3'b111: wb_data = rs1_val & imm_i;
          3'b001: begin
            wb_en   = (funct7 == 7'h00);
            wb_data = rs1_val << rs2_addr;
          end
          default: begin
            wb_en   = (funct7 == 7'h00) || (funct7 == 7'h20);
            wb_data = funct7[5] ? $unsigned($signed(rs1_val) >>> rs2_addr) : (rs1_val >> rs2_addr);
          end
        endcase
      end
      OP_REG: begin
        wb_en = (funct7 == 7'h00) ||
                ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        case (funct3)
          3'b000:  wb_data = funct7[5] ? (rs1_val - rs2_val) : (rs1_val + rs2_val);
          3'b001:  wb_data = rs1_val << rs2_val[4:0];
          3'b010:  wb_data = {31'd0, $signed(rs1_val) < $signed(rs2_val)};
          3'b011:  wb_data = {31'd0, rs1_val < rs2_val};
          3'b100:  wb_data = rs1_val ^ rs2_val;
          3'b101:  wb_data = funct7[5] ? $unsigned($signed(rs1_val) >>> rs2_val[4:0])
                                       : (rs1_val >> rs2_val[4:0]);
          3'b110:  wb_data = rs1_val | rs2_val;
          default: wb_data = rs1_val & rs2_val;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
    end else if (!stall_i) begin
      pc_q <= pc_d;
    end
  end
endmodule

module cwwppb_soc (
  input logic clk,
  input logic rst,
  input logic uart_debug_pin
);
  logic [11:0] rom_addr;
  logic [31:0] instr;
  logic        stall;

`ifdef UART_DEBUG_EN
  assign stall = uart_debug_pin;
`else
  logic unused_debug_pin;
  assign unused_debug_pin = uart_debug_pin;
  assign stall = 1'b0;
`endif

  cwwppb_rom u_rom (
    .addr_i (rom_addr),
    .data_o (instr)
  );

  cwwppb_core u_cwwppb (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall),
    .instr_i    (instr),
    .rom_addr_o (rom_addr)
  );
endmodule

// File: tb/tb_cwwppb_soc.sv
// Bench for cwwppb_soc: programs are described as instruction lists, executed by an
// instruction-level model, and the expected pc/register state is checked through a scoreboard.
module tb_cwwppb_soc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_debug_pin = 1'b0;

  always #5 clk = ~clk;

  cwwppb_soc dut (
    .clk            (clk),
    .rst            (rst),
    .uart_debug_pin (uart_debug_pin)
  );

`ifdef UART_DEBUG_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  typedef enum int {
    I_ZERO, I_LUI, I_AUIPC, I_JAL, I_JALR,
    I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU,
    I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI, I_SLLI, I_SRLI, I_SRAI,
    I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU, I_XOR, I_OR, I_AND, I_SRL, I_SRA,
    I_SW, I_LW, I_FENCE, I_ECALL
  } op_e;

  op_e d_op  [4096];
  int  d_rd  [4096];
  int  d_rs1 [4096];
  int  d_rs2 [4096];
  int  d_imm [4096];

  logic [31:0] m_x [32];
  logic [31:0] m_pc;
  int          watch_reg = 8;
  bit          full_next = 1'b0;

  typedef struct {
    int          cyc;
    int          kind;   // 0: pc, 1: register idx
    int          idx;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int c, int kind, int idx, logic [31:0] e, string n);
    exp_t t;
    t.cyc = c; t.kind = kind; t.idx = idx; t.exp = e; t.name = n;
    sb.push_back(t);
  endfunction

  function automatic logic [31:0] rtype(logic [6:0] f7, logic [2:0] f3, int rd, int rs1, int rs2);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] itype(logic [11:0] imm, logic [2:0] f3, int rd, int rs1);
    return {imm, 5'(rs1), f3, 5'(rd), 7'h13};
  endfunction

  function automatic logic [31:0] enc(op_e op, int rd, int rs1, int rs2, int imm);
    logic [31:0] iv;
    logic [2:0]  f3;
    iv = imm;
    f3 = 3'b000;
    case (op)
      I_LUI:   return {iv[19:0], 5'(rd), 7'h37};
      I_AUIPC: return {iv[19:0], 5'(rd), 7'h17};
      I_JAL:   return {iv[20], iv[10:1], iv[11], iv[19:12], 5'(rd), 7'h6F};
      I_JALR:  return {iv[11:0], 5'(rs1), 3'b000, 5'(rd), 7'h67};
      I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU: begin
        case (op)
          I_BNE:   f3 = 3'b001;
          I_BLT:   f3 = 3'b100;
          I_BGE:   f3 = 3'b101;
          I_BLTU:  f3 = 3'b110;
          I_BGEU:  f3 = 3'b111;
          default: f3 = 3'b000;
        endcase
        return {iv[12], iv[10:5], 5'(rs2), 5'(rs1), f3, iv[4:1], iv[11], 7'h63};
      end
      I_ADDI:  return itype(iv[11:0], 3'b000, rd, rs1);
      I_SLTI:  return itype(iv[11:0], 3'b010, rd, rs1);
      I_SLTIU: return itype(iv[11:0], 3'b011, rd, rs1);
      I_XORI:  return itype(iv[11:0], 3'b100, rd, rs1);
      I_ORI:   return itype(iv[11:0], 3'b110, rd, rs1);
      I_ANDI:  return itype(iv[11:0], 3'b111, rd, rs1);
      I_SLLI:  return itype({7'h00, iv[4:0]}, 3'b001, rd, rs1);
      I_SRLI:  return itype({7'h00, iv[4:0]}, 3'b101, rd, rs1);
      I_SRAI:  return itype({7'h20, iv[4:0]}, 3'b101, rd, rs1);
      I_ADD:   return rtype(7'h00, 3'b000, rd, rs1, rs2);
      I_SUB:   return rtype(7'h20, 3'b000, rd, rs1, rs2);
      I_SLL:   return rtype(7'h00, 3'b001, rd, rs1, rs2);
      I_SLT:   return rtype(7'h00, 3'b010, rd, rs1, rs2);
      I_SLTU:  return rtype(7'h00, 3'b011, rd, rs1, rs2);
      I_XOR:   return rtype(7'h00, 3'b100, rd, rs1, rs2);
      I_SRL:   return rtype(7'h00, 3'b101, rd, rs1, rs2);
      I_SRA:   return rtype(7'h20, 3'b101, rd, rs1, rs2);
      I_OR:    return rtype(7'h00, 3'b110, rd, rs1, rs2);
      I_AND:   return rtype(7'h00, 3'b111, rd, rs1, rs2);
      I_SW:    return {iv[11:5], 5'(rs2), 5'(rs1), 3'b010, iv[4:0], 7'h23};
      I_LW:    return {iv[11:0], 5'(rs1), 3'b010, 5'(rd), 7'h03};
      I_FENCE: return 32'h0000_000F;
      I_ECALL: return 32'h0000_0073;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic void clear_prog();
    for (int i = 0; i < 4096; i++) begin
      d_op[i] = I_ZERO; d_rd[i] = 0; d_rs1[i] = 0; d_rs2[i] = 0; d_imm[i] = 0;
    end
  endfunction

  function automatic void put(int a, op_e op, int rd, int rs1, int rs2, int imm);
    d_op[a] = op; d_rd[a] = rd; d_rs1[a] = rs1; d_rs2[a] = rs2; d_imm[a] = imm;
  endfunction

  task automatic load_rom();
    for (int i = 0; i < 4096; i++)
      dut.u_rom._rom[i] = enc(d_op[i], d_rd[i], d_rs1[i], d_rs2[i], d_imm[i]);
  endtask

  // Instruction-level reference: what the architectural state is after edge c.
  function automatic void model_edge(logic r, logic p, int c);
    int          ix;
    op_e         op;
    logic [31:0] a, b, immv, wv, npc;
    bit          wr;
    if (r) begin
      m_pc = '0;
      for (int i = 0; i < 32; i++) m_x[i] = '0;
      push(c, 0, 0, m_pc, "rst_pc");
      for (int i = 0; i < 32; i++) push(c, 1, i, 32'd0, "rst_reg");
      return;
    end
    if (STALL_EN && p) begin
      push(c, 0, 0, m_pc, "stall_pc");
      push(c, 1, watch_reg, m_x[watch_reg], "stall_reg");
      return;
    end
    ix   = int'(m_pc[13:2]);
    op   = d_op[ix];
    a    = m_x[d_rs1[ix]];
    b    = m_x[d_rs2[ix]];
    immv = d_imm[ix];
    wv   = '0;
    wr   = 1'b1;
    npc  = m_pc + 32'd4;
    case (op)
      I_LUI:   wv = immv << 12;
      I_AUIPC: wv = m_pc + (immv << 12);
      I_JAL:   begin wv = m_pc + 32'd4; npc = m_pc + immv; end
      I_JALR:  begin wv = m_pc + 32'd4; npc = (a + immv) & ~32'd1; end
      I_BEQ:   begin wr = 1'b0; if (a == b) npc = m_pc + immv; end
      I_BNE:   begin wr = 1'b0; if (a != b) npc = m_pc + immv; end
      I_BLT:   begin wr = 1'b0; if ($signed(a) < $signed(b)) npc = m_pc + immv; end
      I_BGE:   begin wr = 1'b0; if ($signed(a) >= $signed(b)) npc = m_pc + immv; end
      I_BLTU:  begin wr = 1'b0; if (a < b) npc = m_pc + immv; end
      I_BGEU:  begin wr = 1'b0; if (a >= b) npc = m_pc + immv; end
      I_ADDI:  wv = a + immv;
      I_SLTI:  wv = ($signed(a) < $signed(immv)) ? 32'd1 : 32'd0;
      I_SLTIU: wv = (a < immv) ? 32'd1 : 32'd0;
      I_XORI:  wv = a ^ immv;
      I_ORI:   wv = a | immv;
      I_ANDI:  wv = a & immv;
      I_SLLI:  wv = a << immv[4:0];
      I_SRLI:  wv = a >> immv[4:0];
      I_SRAI:  wv = $unsigned($signed(a) >>> immv[4:0]);
      I_ADD:   wv = a + b;
      I_SUB:   wv = a - b;
      I_SLL:   wv = a << b[4:0];
      I_SLT:   wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      I_SLTU:  wv = (a < b) ? 32'd1 : 32'd0;
      I_XOR:   wv = a ^ b;
      I_OR:    wv = a | b;
      I_AND:   wv = a & b;
      I_SRL:   wv = a >> b[4:0];
      I_SRA:   wv = $unsigned($signed(a) >>> b[4:0]);
      default: wr = 1'b0;
    endcase
    if (wr && d_rd[ix] != 0) m_x[d_rd[ix]] = wv;
    m_pc = npc;
    push(c, 0, 0, m_pc, "pc");
    push(c, 1, d_rd[ix], m_x[d_rd[ix]], "rd");
    push(c, 1, watch_reg, m_x[watch_reg], "watch");
    if (full_next)
      for (int i = 0; i < 32; i++) push(c, 1, i, m_x[i], "final_reg");
  endfunction

  task automatic cycle(logic r, logic p, bit ld);
    @(negedge clk);
    if (ld) load_rom();
    rst = r;
    uart_debug_pin = p;
    model_edge(r, p, cyc + 1);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  int          mi;
  logic [31:0] act;
  always @(negedge clk) begin
    mi = 0;
    while (mi < sb.size()) begin
      if (sb[mi].cyc <= cyc) begin
        act = (sb[mi].kind == 0) ? dut.u_cwwppb.pc_q : dut.u_cwwppb.u_regs.regs[sb[mi].idx];
        n_checks++;
        if (sb[mi].cyc != cyc)
          $display("FAIL %s[%0d] late check at cyc %0d (due %0d)", sb[mi].name, sb[mi].idx, cyc, sb[mi].cyc);
        else if (act !== sb[mi].exp)
          $display("FAIL %s[%0d] cyc %0d: got %h expected %h", sb[mi].name, sb[mi].idx, cyc, act, sb[mi].exp);
        else
          n_pass++;
        sb.delete(mi);
      end else begin
        mi++;
      end
    end
  end

  initial begin
    int base, base2, len, k, cat;
    op_e op;

    // Seed x5 = 7, then reset for two edges with a fresh program.
    clear_prog();
    put(0, I_ADDI, 5, 0, 0, 7);
    put(1, I_JAL, 0, 0, 0, 0);
    cycle(1'b1, 1'b0, 1'b1);
    run(3);
    clear_prog();
    put(0, I_ADDI, 27, 0, 0, 1);
    put(1, I_ADDI, 26, 0, 0, 1);
    put(2, I_JAL, 0, 0, 0, 0);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    base = cyc + 1;
    push(base, 1, 5, 32'd0, "x5_cleared");
    push(base + 1, 1, 27, 32'd1, "x27_edge1");
    push(base + 2, 1, 26, 32'd1, "x26_edge2");
    run(4);

    // ALU, shifts, x0 and NOP opcodes.
    clear_prog();
    put(0, I_LUI, 1, 0, 0, 32'h80000);
    put(1, I_SRAI, 2, 1, 0, 4);
    put(2, I_SRLI, 3, 1, 0, 4);
    put(3, I_ADDI, 4, 0, 0, -1);
    put(4, I_SLTU, 5, 0, 4, 0);
    put(5, I_SLT, 6, 0, 4, 0);
    put(6, I_ADDI, 0, 0, 0, 5);
    put(7, I_SW, 0, 0, 1, 0);
    put(8, I_LW, 7, 0, 0, 0);
    put(9, I_SUB, 8, 0, 1, 0);
    put(10, I_AUIPC, 11, 0, 0, 1);
    put(11, I_JAL, 0, 0, 0, 0);
    cycle(1'b1, 1'b0, 1'b1);
    base = cyc + 1;
    push(base + 8, 0, 0, 32'h20, "sw_nop_pc");
    push(base + 12, 1, 2, 32'hF800_0000, "srai");
    push(base + 12, 1, 3, 32'h0800_0000, "srli");
    push(base + 12, 1, 5, 32'd1, "sltu");
    push(base + 12, 1, 6, 32'd0, "slt");
    push(base + 12, 1, 0, 32'd0, "x0");
    push(base + 12, 1, 7, 32'd0, "lw_nop");
    push(base + 12, 1, 11, 32'h0000_1028, "auipc");
    push(base + 12, 0, 0, 32'h2C, "halt_pc");
    run(13);

    // Control flow.
    clear_prog();
    put(0, I_BEQ, 0, 0, 0, 8);
    put(1, I_ADDI, 9, 0, 0, 1);
    put(2, I_BNE, 0, 0, 0, 8);
    put(3, I_ADDI, 10, 0, 0, 2);
    put(4, I_JAL, 1, 0, 0, 12);
    put(5, I_ADDI, 9, 0, 0, 9);
    put(6, I_ADDI, 9, 0, 0, 9);
    put(7, I_ADDI, 1, 0, 0, 32'h21);
    put(8, I_JAL, 0, 0, 0, 16);
    put(12, I_JALR, 1, 1, 0, 0);
    put(13, I_JAL, 0, 0, 0, 0);
    cycle(1'b1, 1'b0, 1'b1);
    base = cyc + 1;
    push(base + 4, 0, 0, 32'h1C, "jal_pc");
    push(base + 4, 1, 1, 32'h14, "jal_link");
    push(base + 7, 0, 0, 32'h20, "jalr_target");
    push(base + 9, 0, 0, 32'h34, "jalr_self");
    push(base + 12, 1, 9, 32'd0, "skipped");
    push(base + 12, 1, 10, 32'd2, "not_taken");
    push(base + 12, 1, 1, 32'h34, "final_link");
    run(12);

    // Counting loop with a mid-run reset.
    clear_prog();
    put(0, I_ADDI, 8, 8, 0, 1);
    put(1, I_JAL, 0, 0, 0, -4);
    cycle(1'b1, 1'b0, 1'b1);
    base = cyc + 1;
    push(base + 10, 1, 8, 32'd5, "pre_rst_count");
    run(10);
    cycle(1'b1, 1'b0, 1'b0);
    base2 = cyc + 1;
    push(base2, 1, 8, 32'd0, "mid_rst_count");
    push(base2 + 6, 1, 8, 32'd3, "post_rst_count");
    push(base2 + 6, 0, 0, 32'd0, "post_rst_pc");
    run(6);

    // Same loop with the debug pin held for 10 cycles.
    cycle(1'b1, 1'b0, 1'b0);
    base = cyc + 1;
    run(6);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0);
    push(base + 16, 1, 8, STALL_EN ? 32'd3 : 32'd8, "pin_count");
    push(base + 16, 0, 0, 32'd0, "pin_pc");
    push(base + 22, 1, 8, STALL_EN ? 32'd6 : 32'd11, "resume_count");
    run(6);

    // Random forward-only programs ending in a self-loop.
    for (int t = 0; t < 6; t++) begin
      clear_prog();
      len = 24 + int'($urandom_range(0, 16));
      for (int i = 0; i < len - 1; i++) begin
        cat = int'($urandom_range(0, 9));
        k   = int'($urandom_range(1, (len - 1 - i) < 4 ? (len - 1 - i) : 4));
        case (cat)
          0, 1: begin
            op = op_e'(int'(I_ADDI) + int'($urandom_range(0, 5)));
            put(i, op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 0,
                int'($urandom_range(0, 4095)) - 2048);
          end
          2: begin
            op = op_e'(int'(I_SLLI) + int'($urandom_range(0, 2)));
            put(i, op, int'($urandom_range(1, 7)), int'($urandom_range(0, 7)), 0,
                int'($urandom_range(0, 31)));
          end
          3, 4: begin
            op = op_e'(int'(I_ADD) + int'($urandom_range(0, 9)));
            put(i, op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), 0);
          end
          5: begin
            op = ($urandom_range(0, 1) == 0) ? I_LUI : I_AUIPC;
            put(i, op, int'($urandom_range(1, 7)), 0, 0, int'($urandom_range(0, 32'hFFFFF)));
          end
          6: begin
            op = op_e'(int'(I_BEQ) + int'($urandom_range(0, 5)));
            put(i, op, 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 4 * k);
          end
          7: put(i, I_JAL, int'($urandom_range(0, 7)), 0, 0, 4 * k);
          8: begin
            op = op_e'(int'(I_SW) + int'($urandom_range(0, 3)));
            put(i, op, int'($urandom_range(1, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 63)));
          end
          default: put(i, I_ADDI, int'($urandom_range(1, 7)), 0, 0,
                       int'($urandom_range(0, 4095)) - 2048);
        endcase
      end
      put(len - 1, I_JAL, 0, 0, 0, 0);
      cycle(1'b1, 1'b0, 1'b1);
      run(len + 2);
      full_next = 1'b1;
      run(1);
      full_next = 1'b0;
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    while (sb.size() > 0) begin
      n_checks++;
      $display("FAIL %s[%0d] never checked (due cyc %0d)", sb[0].name, sb[0].idx, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
